trap_sequencer: RTL

//  Per-hart trap/MRET request collector and round-robin scheduler in front of csr_file's single

---
 rtl/trap_sequencer_if.sv | 45 ++++
 rtl/trap_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: bundle of every non-clock/reset signal of trap_sequencer.
//   master : requesting environment (harts, csr_file read-back, fetch stage)
//   slave  : the sequencer itself
// Groups: per-hart request port (req_*), hart stall (hart_busy), csr_file trap
// port (trap_*), csr_file read-back select (csr_sel_*, mtvec_i, mepc_i) and the
// fetch redirect handshake (redirect_*).
interface trap_sequencer_if #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2,
  parameter int XLEN      = 32
);
  logic [HART_NUM-1:0]      req_valid;
  logic [HART_NUM-1:0]      req_ready;
  logic [2*HART_NUM-1:0]    req_kind;
  logic [XLEN*HART_NUM-1:0] req_pc;
  logic [XLEN*HART_NUM-1:0] req_cause;
  logic [HART_NUM-1:0]      hart_busy;
  logic                     trap_set;
  logic                     trap_mret;
  logic [HART_ID_W-1:0]     trap_hart_id;
  logic [XLEN-1:0]          trap_mepc;
  logic [XLEN-1:0]          trap_mcause;
  logic                     csr_sel_valid;
  logic [HART_ID_W-1:0]     csr_sel_hart;
  logic [XLEN-1:0]          mtvec_i;
  logic [XLEN-1:0]          mepc_i;
  logic                     redirect_valid;
  logic                     redirect_ready;
  logic [HART_ID_W-1:0]     redirect_hart;
  logic [XLEN-1:0]          redirect_pc;

  modport master (
    output req_valid, req_kind, req_pc, req_cause, mtvec_i, mepc_i, redirect_ready,
    input  req_ready, hart_busy, trap_set, trap_mret, trap_hart_id, trap_mepc,
           trap_mcause, csr_sel_valid, csr_sel_hart, redirect_valid, redirect_hart,
           redirect_pc
  );

  modport slave (
    input  req_valid, req_kind, req_pc, req_cause, mtvec_i, mepc_i, redirect_ready,
    output req_ready, hart_busy, trap_set, trap_mret, trap_hart_id, trap_mepc,
           trap_mcause, csr_sel_valid, csr_sel_hart, redirect_valid, redirect_hart,
           redirect_pc
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: per-hart trap/MRET request collector and round-robin
// scheduler in front of csr_file's single trap port. One request is buffered
// per hart; one hart at a time is granted, pulses trap_set/trap_mret, has its
// mtvec/mepc read back and receives a redirect PC for fetch.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous reset, active-high
//   bus  : trap_sequencer_if.slave (request, trap, CSR read-back, redirect)

// Per-hart request buffer. Holds one request until its redirect handshake.
module trap_slot #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [1:0]      kind,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] cause,
  input  logic            clr,
  output logic            pend,
  output logic [1:0]      kind_q,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] cause_q
);
  // clr only fires for a pending slot and accept needs ~pend: never both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= 1'b0;
      kind_q  <= '0;
      pc_q    <= '0;
      cause_q <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (valid && !pend && kind != 2'b11) begin
      pend    <= 1'b1;
      kind_q  <= kind;
      pc_q    <= pc;
      cause_q <= cause;
    end
  end
endmodule

module trap_sequencer #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  trap_sequencer_if.slave bus
);
  localparam logic [1:0] K_EXC  = 2'b00;
  localparam logic [1:0] K_INT  = 2'b01;
  localparam logic [1:0] K_MRET = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, LOOKUP, RESP} state_t;

  state_t                          state;
  logic [HART_NUM-1:0]             pend;
  logic [HART_NUM-1:0]             clr;
  logic [HART_NUM-1:0][1:0]        kind_q;
  logic [HART_NUM-1:0][XLEN-1:0]   pc_q;
  logic [HART_NUM-1:0][XLEN-1:0]   cause_q;
  logic [HART_ID_W-1:0]            rr_ptr;
  logic [HART_ID_W-1:0]            grant;
  logic [HART_ID_W-1:0]            pick;
  logic [XLEN-1:0]                 base;
  logic [XLEN-1:0]                 nxt_pc;

  logic                 trap_set, trap_mret, csr_sel_valid, redirect_valid;
  logic [HART_ID_W-1:0] trap_hart_id, csr_sel_hart, redirect_hart;
  logic [XLEN-1:0]      trap_mepc, trap_mcause, redirect_pc;

  for (genvar h = 0; h < HART_NUM; h++) begin : g_slot
    trap_slot #(.XLEN(XLEN)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.req_valid[h]),
      .kind    (bus.req_kind[2*h +: 2]),
      .pc      (bus.req_pc[XLEN*h +: XLEN]),
      .cause   (bus.req_cause[XLEN*h +: XLEN]),
      .clr     (clr[h]),
      .pend    (pend[h]),
      .kind_q  (kind_q[h]),
      .pc_q    (pc_q[h]),
      .cause_q (cause_q[h])
    );
  end

  // Pending bit of the granted hart drops on its redirect handshake only.
  always_comb begin
    clr = '0;
    if (state == RESP && bus.redirect_ready) clr[grant] = 1'b1;
  end

  // Round-robin: first pending hart at or above rr_ptr, wrapping.
  always_comb begin
    logic [HART_ID_W-1:0] idx;
    logic                 found;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < HART_NUM; i++) begin
      idx = HART_ID_W'((int'(rr_ptr) + i) % HART_NUM);
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Redirect target from the CSR values read back during LOOKUP. Vectored
  // mtvec (mode 01) sends machine external interrupts (cause 11) to base+4*11.
  always_comb begin
    base = {bus.mtvec_i[XLEN-1:2], 2'b00};
    case (kind_q[grant])
      K_MRET:  nxt_pc = bus.mepc_i;
      K_INT:   nxt_pc = (bus.mtvec_i[1:0] == 2'b01) ? base + XLEN'(44) : base;
      default: nxt_pc = base;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant          <= '0;
      trap_set       <= 1'b0;
      trap_mret      <= 1'b0;
      trap_hart_id   <= '0;
      trap_mepc      <= '0;
      trap_mcause    <= '0;
      csr_sel_valid  <= 1'b0;
      csr_sel_hart   <= '0;
      redirect_valid <= 1'b0;
      redirect_hart  <= '0;
      redirect_pc    <= '0;
    end else begin
      // Trap and select strobes are single-cycle; default them low.
      trap_set      <= 1'b0;
      trap_mret     <= 1'b0;
      trap_hart_id  <= '0;
      trap_mepc     <= '0;
      trap_mcause   <= '0;
      csr_sel_valid <= 1'b0;
      csr_sel_hart  <= '0;
      case (state)
        IDLE: if (|pend) begin
          grant        <= pick;
          trap_hart_id <= pick;
          state        <= ISSUE;
          case (kind_q[pick])
            K_EXC: begin
              trap_set    <= 1'b1;
              trap_mepc   <= pc_q[pick];
              trap_mcause <= cause_q[pick] & {1'b0, {(XLEN-1){1'b1}}};
            end
            K_INT: begin
              trap_set    <= 1'b1;
              trap_mepc   <= pc_q[pick];
              trap_mcause <= {1'b1, (XLEN-1)'(11)};
            end
            default: trap_mret <= 1'b1;
          endcase
        end
        ISSUE: begin
          csr_sel_valid <= 1'b1;
          csr_sel_hart  <= grant;
          state         <= LOOKUP;
        end
        LOOKUP: begin
          redirect_pc    <= nxt_pc;
          redirect_valid <= 1'b1;
          redirect_hart  <= grant;
          state          <= RESP;
        end
        RESP: if (bus.redirect_ready) begin
          redirect_valid <= 1'b0;
          redirect_hart  <= '0;
          rr_ptr         <= (grant == HART_ID_W'(HART_NUM-1)) ? '0 : grant + HART_ID_W'(1);
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = ~pend;
  assign bus.hart_busy      = pend;
  assign bus.trap_set       = trap_set;
  assign bus.trap_mret      = trap_mret;
  assign bus.trap_hart_id   = trap_hart_id;
  assign bus.trap_mepc      = trap_mepc;
  assign bus.trap_mcause    = trap_mcause;
  assign bus.csr_sel_valid  = csr_sel_valid;
  assign bus.csr_sel_hart   = csr_sel_hart;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_hart  = redirect_hart;
  assign bus.redirect_pc    = redirect_pc;
endmodule
